// File: rtl/mem_bus_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_prio_starve.sv
// Data-priority grant selection with a starvation counter that forces an
// instruction grant after STARVE_LIMIT consecutive data wins over a waiting fetch.
module arb_prio_starve
  import mem_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inst_req,
  input  logic   data_req,
  input  logic   grant_en,
  output owner_t grant_c
);

  logic [CNT_W-1:0] starve_cnt;
  logic             inst_forced;

  assign inst_forced = inst_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_c = OWN_NONE;
    if (data_req && !inst_forced) begin
      grant_c = OWN_DATA;
    end else if (inst_req) begin
      grant_c = OWN_INST;
    end
  end

  // Counter moves only on an actual grant; saturates while fetch keeps losing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (grant_c == OWN_DATA && inst_req) begin
        if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else if (grant_c != OWN_NONE) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch and data requesters, sequencing
// one address/data transaction at a time and routing handshakes to the owner.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned A_WIDTH      = 32,
  parameter int unsigned D_WIDTH      = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [1:0]         inst_size,
  input  logic [A_WIDTH-1:0] inst_addr,
  input  logic [D_WIDTH-1:0] inst_wdata,
  output logic [D_WIDTH-1:0] inst_rdata,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [1:0]         data_size,
  input  logic [A_WIDTH-1:0] data_addr,
  input  logic [D_WIDTH-1:0] data_wdata,
  output logic [D_WIDTH-1:0] data_rdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic               m_req,
  output logic               m_wr,
  output logic [1:0]         m_size,
  output logic [A_WIDTH-1:0] m_addr,
  output logic [D_WIDTH-1:0] m_wdata,
  input  logic [D_WIDTH-1:0] m_rdata,
  input  logic               m_addr_ok,
  input  logic               m_data_ok,
  output logic               busy
);

  state_t             state, state_nx;
  owner_t             owner, owner_nx;
  owner_t             grant;
  logic               grant_en;
  logic               addr_hit, data_hit;
  logic               wr_nx;
  logic [1:0]         size_nx;
  logic [A_WIDTH-1:0] addr_nx;
  logic [D_WIDTH-1:0] wdata_nx;

  arb_prio_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .inst_req (inst_req),
    .data_req (data_req),
    .grant_en (grant_en),
    .grant_c  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= OWN_NONE;
      m_req   <= 1'b0;
      busy    <= 1'b0;
      m_wr    <= 1'b0;
      m_size  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      m_req   <= (state_nx == ST_ADDR);
      busy    <= (state_nx != ST_IDLE);
      m_wr    <= wr_nx;
      m_size  <= size_nx;
      m_addr  <= addr_nx;
      m_wdata <= wdata_nx;
    end
  end

  // Grant and field capture in IDLE; handshakes from the bus are only honoured outside IDLE.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    grant_en = 1'b0;
    addr_hit = 1'b0;
    data_hit = 1'b0;
    wr_nx    = m_wr;
    size_nx  = m_size;
    addr_nx  = m_addr;
    wdata_nx = m_wdata;
    case (state)
      ST_IDLE: begin
        grant_en = 1'b1;
        if (grant == OWN_DATA) begin
          owner_nx = OWN_DATA;
          state_nx = ST_ADDR;
          wr_nx    = data_wr;
          size_nx  = data_size;
          addr_nx  = data_addr;
          wdata_nx = data_wdata;
        end else if (grant == OWN_INST) begin
          owner_nx = OWN_INST;
          state_nx = ST_ADDR;
          wr_nx    = inst_wr;
          size_nx  = inst_size;
          addr_nx  = inst_addr;
          wdata_nx = inst_wdata;
        end
      end
      ST_ADDR: begin
        if (m_addr_ok) begin
          addr_hit = 1'b1;
          if (m_data_ok) begin
            data_hit = 1'b1;
            state_nx = ST_IDLE;
            owner_nx = OWN_NONE;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (m_data_ok) begin
          data_hit = 1'b1;
          state_nx = ST_IDLE;
          owner_nx = OWN_NONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        owner_nx = OWN_NONE;
      end
    endcase
  end

  always_comb begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (owner == OWN_INST) begin
      inst_addr_ok = addr_hit;
      inst_data_ok = data_hit;
    end else if (owner == OWN_DATA) begin
      data_addr_ok = addr_hit;
      data_data_ok = data_hit;
    end
  end

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch requester (I-cache miss path) and the data requester (D-side load/store).
- Sequences one transaction at a time through address phase then data phase, and routes addr_ok/data_ok back to the owning requester.
- Data side has priority; a starvation counter guarantees instruction progress.
- Sits between the cache/LSU ports and the bus bridge.

Parameters:
- A_WIDTH, 32, address width.
- D_WIDTH, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inst_req  in  1  instruction request; held with its fields until inst_addr_ok.
- inst_wr  in  1  write flag (always 0 from fetch, still forwarded).
- inst_size  in  2  transfer size.
- inst_addr  in  A_WIDTH  address.
- inst_wdata  in  D_WIDTH  write data.
- inst_rdata  out  D_WIDTH  read data.
- inst_addr_ok  out  1  address accepted.
- inst_data_ok  out  1  data returned.
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/A_WIDTH/D_WIDTH  same semantics for the data side.
- data_rdata  out  D_WIDTH; data_addr_ok  out  1; data_data_ok  out  1.
- m_req  out  1  bus request.
- m_wr  out  1  bus write flag.
- m_size  out  2  bus size.
- m_addr  out  A_WIDTH  bus address.
- m_wdata  out  D_WIDTH  bus write data.
- m_rdata  in  D_WIDTH  bus read data.
- m_addr_ok  in  1  bus address accept.
- m_data_ok  in  1  bus data return.
- busy  out  1  state != IDLE.

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values:
  - state=IDLE, owner=NONE, starve_cnt=0.
  - m_req=0; m_wr, m_size, m_addr, m_wdata all 0.
  - All addr_ok/data_ok=0, busy=0.
- FSM IDLE:
  - If data_req and not (inst_req and starve_cnt==STARVE_LIMIT): grant DATA.
  - Else if inst_req: grant INST.
  - On grant, latch wr/size/addr/wdata from the winner into bus registers and go to ADDR.
  - No combinational path from req to m_req: first m_req is one cycle after the request is seen.
- FSM ADDR:
  - m_req=1 with the latched fields.
  - When m_addr_ok=1, assert owner's *_addr_ok in the same cycle (combinational pass-through), drop m_req next cycle, and go to WAIT.
  - If m_data_ok is also 1 in that cycle, assert owner's *_data_ok too and go to IDLE.
- FSM WAIT:
  - On m_data_ok, assert owner's *_data_ok the same cycle and go to IDLE. Otherwise hold.
- Routing:
  - inst_rdata = data_rdata = m_rdata, unconditional broadcast.
  - *_addr_ok and *_data_ok are gated by owner and state. The non-owner always sees 0.
  - m_addr_ok or m_data_ok arriving in IDLE (spurious) is ignored.
- Latency: minimum request-to-data_ok is 2 cycles (IDLE grant, then ADDR with same-cycle addr_ok and data_ok). Back-to-back transactions need one IDLE cycle between them.
- starve_cnt (4 bits), updated at grant time:
  - DATA granted while inst_req=1: increment, saturating at STARVE_LIMIT.
  - INST granted, or DATA granted with inst_req=0: clear to 0.
- Simultaneous requests in IDLE: data wins unless starve_cnt==STARVE_LIMIT, in which case inst wins and the counter clears.
- A requester dropping req while in ADDR is a protocol violation and is not supported; the latched fields are still issued.
- Reset mid-transaction: everything returns to reset values immediately. Any bus response still in flight after reset is ignored in IDLE.
- Single outstanding transaction only; no pipelining of a second address phase.

Decomposition:
- Shared package mem_bus_pkg:
  - owner enum {OWN_NONE, OWN_INST, OWN_DATA}.
  - state enum {ST_IDLE, ST_ADDR, ST_WAIT}.
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- One natural sub-module, arb_prio_starve: pure grant logic plus the starve_cnt register. Takes inst_req, data_req, grant_en; outputs the grant.
- The FSM, field latches and response routing stay in the top module.

Test Plan:
- Single inst read:
  - Stimulus: inst_req=1, addr=0xBFC00000; bus gives addr_ok in the 1st ADDR cycle and data_ok 2 cycles later with 0x3C08BFC0.
  - Response: m_req high exactly 1 cycle; inst_addr_ok pulses once; inst_data_ok pulses with inst_rdata=0x3C08BFC0; data_* ok outputs stay 0.
- Simultaneous requests: inst_req and data_req (wr=1, addr=0x80001000, wdata=0xDEADBEEF) both asserted in IDLE -> data is served first with m_wr=1 and m_wdata=0xDEADBEEF; inst is served next after one IDLE cycle.
- Starvation: data_req and inst_req held high continuously with STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Same-cycle addr_ok and data_ok: bus asserts m_addr_ok=m_data_ok=1 in the first ADDR cycle -> owner's addr_ok and data_ok pulse together, the FSM returns to IDLE, and the next m_req is 2 cycles later.
- Async reset: rst asserted mid-cycle while in WAIT -> m_req, busy and all ok outputs are 0 before the next clk edge; a late m_data_ok produces no *_data_ok.
- Bus stall: m_addr_ok held low for 10 cycles -> m_req, m_addr and m_wdata stay constant; no ok pulses occur.
